// File: rtl/fp_divsqrt_arbiter_if.sv
// Signal bundle between the APU requesters, the div/sqrt arbiter and the shared div/sqrt unit.
// Names carry the arbiter's direction suffix; the arbiter uses the slave modport.
interface fp_divsqrt_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 4
) ();
  logic [NREQ-1:0]           req_i;
  logic [NREQ-1:0]           gnt_o;
  logic [NREQ*FP_WIDTH-1:0]  opa_i;
  logic [NREQ*FP_WIDTH-1:0]  opb_i;
  logic [NREQ-1:0]           sqrt_i;
  logic [NREQ*RND_WIDTH-1:0] rnd_i;
  logic [NREQ*TAG_WIDTH-1:0] tag_i;
  logic [NREQ-1:0]           resp_valid_o;
  logic [FP_WIDTH-1:0]       res_o;
  logic [STAT_WIDTH-1:0]     status_o;
  logic [TAG_WIDTH-1:0]      tag_o;
  logic                      busy_o;
  logic                      du_en_o;
  logic [FP_WIDTH-1:0]       du_opa_o;
  logic [FP_WIDTH-1:0]       du_opb_o;
  logic                      du_sqrt_o;
  logic [RND_WIDTH-1:0]      du_rnd_o;
  logic [TAG_WIDTH-1:0]      du_tag_o;
  logic                      du_ready_i;
  logic                      du_valid_i;
  logic [FP_WIDTH-1:0]       du_res_i;
  logic [STAT_WIDTH-1:0]     du_status_i;
  logic [TAG_WIDTH-1:0]      du_tag_i;

  modport slave (
    input  req_i, opa_i, opb_i, sqrt_i, rnd_i, tag_i,
    input  du_ready_i, du_valid_i, du_res_i, du_status_i, du_tag_i,
    output gnt_o, resp_valid_o, res_o, status_o, tag_o, busy_o,
    output du_en_o, du_opa_o, du_opb_o, du_sqrt_o, du_rnd_o, du_tag_o
  );

  modport master (
    output req_i, opa_i, opb_i, sqrt_i, rnd_i, tag_i,
    output du_ready_i, du_valid_i, du_res_i, du_status_i, du_tag_i,
    input  gnt_o, resp_valid_o, res_o, status_o, tag_o, busy_o,
    input  du_en_o, du_opa_o, du_opb_o, du_sqrt_o, du_rnd_o, du_tag_o
  );
endinterface

// File: rtl/fp_divsqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative FP div/sqrt unit among NREQ requesters.
// Define FP_DIVSQRT_ARB_RESP_REG_EN to register the response bus (one extra cycle of latency).
module fp_divsqrt_arbiter #(
  parameter int NREQ       = 4,
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fp_divsqrt_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     id_q, id_d;
  logic [PTR_W-1:0]     win;
  logic                 found;
  logic                 issue;
  logic                 resp_fire;
  logic [NREQ-1:0]      resp_valid_d;
  logic [FP_WIDTH-1:0]  res_d;
  logic [STAT_WIDTH-1:0] status_d;
  logic [TAG_WIDTH-1:0] tag_d;

  logic [FP_WIDTH-1:0]  opa_arr [NREQ];
  logic [FP_WIDTH-1:0]  opb_arr [NREQ];
  logic [RND_WIDTH-1:0] rnd_arr [NREQ];
  logic [TAG_WIDTH-1:0] tag_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign opa_arr[gi] = bus.opa_i[gi*FP_WIDTH +: FP_WIDTH];
      assign opb_arr[gi] = bus.opb_i[gi*FP_WIDTH +: FP_WIDTH];
      assign rnd_arr[gi] = bus.rnd_i[gi*RND_WIDTH +: RND_WIDTH];
      assign tag_arr[gi] = bus.tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
    end
  endgenerate

  // First requester at or above ptr_q, wrapping at NREQ-1 (NREQ need not be a power of two).
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_c;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_c = PTR_W'(idx);
      if (!found && bus.req_i[idx_c]) begin
        found = 1'b1;
        win   = idx_c;
      end
    end
  end

  // Gating with rst_ni keeps the combinational issue port quiet while reset is held.
  assign issue = rst_ni && (state_q == IDLE) && found && bus.du_ready_i;

  assign bus.gnt_o     = issue ? (NREQ'(1) << win) : '0;
  assign bus.du_en_o   = issue;
  assign bus.du_opa_o  = issue ? opa_arr[win] : '0;
  assign bus.du_opb_o  = issue ? opb_arr[win] : '0;
  assign bus.du_sqrt_o = issue & bus.sqrt_i[win];
  assign bus.du_rnd_o  = issue ? rnd_arr[win] : '0;
  assign bus.du_tag_o  = issue ? tag_arr[win] : '0;
  assign bus.busy_o    = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          id_d    = win;
          ptr_d   = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
        end
      end
      BUSY: begin
        if (bus.du_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  // A unit result seen in IDLE belongs to an operation killed by reset and is dropped.
  assign resp_fire    = (state_q == BUSY) && bus.du_valid_i;
  assign resp_valid_d = resp_fire ? (NREQ'(1) << id_q) : '0;
  assign res_d        = resp_fire ? bus.du_res_i : '0;
  assign status_d     = resp_fire ? bus.du_status_i : '0;
  assign tag_d        = resp_fire ? bus.du_tag_i : '0;

`ifdef FP_DIVSQRT_ARB_RESP_REG_EN
  logic [NREQ-1:0]       resp_valid_q;
  logic [FP_WIDTH-1:0]   res_q;
  logic [STAT_WIDTH-1:0] status_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= '0;
      res_q        <= '0;
      status_q     <= '0;
      tag_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      res_q        <= res_d;
      status_q     <= status_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.resp_valid_o = resp_valid_q;
  assign bus.res_o        = res_q;
  assign bus.status_o     = status_q;
  assign bus.tag_o        = tag_q;
`else
  assign bus.resp_valid_o = resp_valid_d;
  assign bus.res_o        = res_d;
  assign bus.status_o     = status_d;
  assign bus.tag_o        = tag_d;
`endif
endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Directed bench for fp_divsqrt_arbiter: unit model with 5-cycle latency, response scoreboard,
// grant-order log, plus a 3-requester instance for the non-power-of-two wrap case.
`timescale 1ns/1ps
module tb_fp_divsqrt_arbiter;
  localparam int NREQ = 4, FPW = 32, TW = 2, RW = 3, SW = 4, DU_LAT = 5;
`ifdef FP_DIVSQRT_ARB_RESP_REG_EN
  localparam int RESP_LAT = 1;
`else
  localparam int RESP_LAT = 0;
`endif

  typedef struct {
    int             who;
    logic [FPW-1:0] res;
    logic [SW-1:0]  st;
    logic [TW-1:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_divsqrt_arbiter_if #(.NREQ(NREQ), .FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW)) bus ();
  fp_divsqrt_arbiter #(.NREQ(NREQ), .FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  fp_divsqrt_arbiter_if #(.NREQ(3), .FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW)) bus3 ();
  fp_divsqrt_arbiter #(.NREQ(3), .FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus3)
  );

  // Requester-side stimulus
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] sqrt_v = '0;
  logic [FPW-1:0]  opa_v [NREQ];
  logic [FPW-1:0]  opb_v [NREQ];
  logic [RW-1:0]   rnd_v [NREQ];
  logic [TW-1:0]   tag_v [NREQ];
  logic            du_ready = 1'b1;
  logic            spur_valid = 1'b0;
  logic [2:0]      req3 = '0;

  always_comb begin
    bus.req_i      = req;
    bus.sqrt_i     = sqrt_v;
    bus.du_ready_i = du_ready;
    bus.opa_i      = '0;
    bus.opb_i      = '0;
    bus.rnd_i      = '0;
    bus.tag_i      = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.opa_i[i*FPW +: FPW] = opa_v[i];
      bus.opb_i[i*FPW +: FPW] = opb_v[i];
      bus.rnd_i[i*RW +: RW]   = rnd_v[i];
      bus.tag_i[i*TW +: TW]   = tag_v[i];
    end
  end

  // Unit model: exponent arithmetic, exact for powers of two (4.0/2.0 -> 2.0, sqrt(16.0) -> 4.0)
  function automatic logic [FPW-1:0] unit_res(input logic [FPW-1:0] a, input logic [FPW-1:0] b, input logic s);
    if (s) return ((a - 32'h3F80_0000) >> 1) + 32'h3F80_0000;
    return a - b + 32'h3F80_0000;
  endfunction

  int             m_cnt = 0;
  logic           m_valid = 1'b0;
  logic [FPW-1:0] m_opa = '0, m_opb = '0;
  logic           m_sqrt = 1'b0;
  logic [RW-1:0]  m_rnd = '0;
  logic [TW-1:0]  m_tag = '0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (bus.du_en_o) begin
      m_cnt  <= DU_LAT - 1;
      m_opa  <= bus.du_opa_o;
      m_opb  <= bus.du_opb_o;
      m_sqrt <= bus.du_sqrt_o;
      m_rnd  <= bus.du_rnd_o;
      m_tag  <= bus.du_tag_o;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end
  end

  assign bus.du_valid_i  = m_valid | spur_valid;
  assign bus.du_res_i    = unit_res(m_opa, m_opb, m_sqrt);
  assign bus.du_status_i = {m_sqrt, m_rnd};
  assign bus.du_tag_i    = m_tag;

  int   m3_cnt = 0;
  logic m3_valid = 1'b0;
  always @(posedge clk) begin
    m3_valid <= 1'b0;
    if (bus3.du_en_o) m3_cnt <= DU_LAT - 1;
    else if (m3_cnt > 0) begin
      m3_cnt <= m3_cnt - 1;
      if (m3_cnt == 1) m3_valid <= 1'b1;
    end
  end

  assign bus3.req_i       = req3;
  assign bus3.opa_i       = '0;
  assign bus3.opb_i       = '0;
  assign bus3.sqrt_i      = '0;
  assign bus3.rnd_i       = '0;
  assign bus3.tag_i       = '0;
  assign bus3.du_ready_i  = 1'b1;
  assign bus3.du_valid_i  = m3_valid;
  assign bus3.du_res_i    = '0;
  assign bus3.du_status_i = '0;
  assign bus3.du_tag_i    = '0;

  // Checking state
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int last_resp_cyc = 0;
  logic [FPW-1:0] last_res = '0;
  logic [TW-1:0]  last_tag = '0;
  int gnt_log[$];
  int gnt_cyc[$];
  int gnt3_log[$];
  exp_t sb[$];
  int rearm_left [NREQ];
  logic [NREQ-1:0] obs_gnt = '0, obs_resp = '0;
  logic obs_busy = 1'b0, obs_du_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push_exp(input int i);
    exp_t e;
    e.who = i;
    e.res = unit_res(opa_v[i], opb_v[i], sqrt_v[i]);
    e.st  = {sqrt_v[i], rnd_v[i]};
    e.tag = tag_v[i];
    sb.push_back(e);
  endtask

  // One clock: sample/check at the falling edge, update requests just after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] rearm;
    logic [2:0]      g3;
    exp_t            e;
    int              w;
    rearm = '0;
    @(negedge clk);
    cyc++;
    g         = bus.gnt_o;
    obs_gnt   = g;
    obs_busy  = bus.busy_o;
    obs_resp  = bus.resp_valid_o;
    obs_du_en = bus.du_en_o;
    if (obs_busy) busy_cnt++;
    if (g != '0) begin
      w = onehot_idx(16'(g));
      gnt_log.push_back(w);
      gnt_cyc.push_back(cyc);
      $display("cyc %0d: grant requester %0d", cyc, w);
      chk("gnt_onehot", 64'($onehot(g)), 64'(1));
      chk("du_en_with_gnt", 64'(bus.du_en_o), 64'(1));
      chk("du_opa", 64'(bus.du_opa_o), 64'(opa_v[w]));
      chk("du_opb", 64'(bus.du_opb_o), 64'(opb_v[w]));
      chk("du_ctl", 64'({bus.du_sqrt_o, bus.du_rnd_o, bus.du_tag_o}), 64'({sqrt_v[w], rnd_v[w], tag_v[w]}));
    end else begin
      chk("du_en_idle", 64'(bus.du_en_o), 64'(0));
      chk("du_ops_idle", 64'({bus.du_opa_o, bus.du_opb_o}), 64'(0));
      chk("du_ctl_idle", 64'({bus.du_sqrt_o, bus.du_rnd_o, bus.du_tag_o}), 64'(0));
    end
    if (obs_resp != '0) begin
      $display("cyc %0d: response valid=%b res=0x%08h status=0x%0h tag=%0d",
               cyc, obs_resp, bus.res_o, bus.status_o, bus.tag_o);
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(obs_resp), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("resp_valid", 64'(obs_resp), 64'(NREQ'(1) << e.who));
        chk("resp_res", 64'(bus.res_o), 64'(e.res));
        chk("resp_status", 64'(bus.status_o), 64'(e.st));
        chk("resp_tag", 64'(bus.tag_o), 64'(e.tag));
        last_resp_cyc = cyc;
        last_res      = bus.res_o;
        last_tag      = bus.tag_o;
        if (rearm_left[e.who] > 0) begin
          rearm_left[e.who]--;
          rearm[e.who] = 1'b1;
          push_exp(e.who);
        end
      end
    end else begin
      chk("resp_idle_zero", 64'({bus.res_o, bus.status_o, bus.tag_o}), 64'(0));
    end
    g3 = bus3.gnt_o;
    if (g3 != '0) begin
      gnt3_log.push_back(onehot_idx(16'(g3)));
      $display("cyc %0d: nreq3 grant requester %0d", cyc, onehot_idx(16'(g3)));
    end
    @(posedge clk);
    #1;
    req  = (req & ~g) | rearm;
    req3 = req3 & ~g3;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy_o || req != '0) && n < bound) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 64'(n < bound), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g0;
    int bbase;
    int rr_exp [5];
    int n3_exp [3];
    rr_exp = '{0, 1, 2, 3, 0};
    n3_exp = '{1, 2, 0};

    opa_v[0] = 32'h4180_0000; opb_v[0] = 32'h4000_0000; rnd_v[0] = 3'd0; tag_v[0] = 2'd1;
    opa_v[1] = 32'h4100_0000; opb_v[1] = 32'h3F80_0000; rnd_v[1] = 3'd2; tag_v[1] = 2'd3;
    opa_v[2] = 32'h4080_0000; opb_v[2] = 32'h4000_0000; rnd_v[2] = 3'd1; tag_v[2] = 2'd2;
    opa_v[3] = 32'h4180_0000; opb_v[3] = 32'hDEAD_BEEF; rnd_v[3] = 3'd4; tag_v[3] = 2'd1;
    sqrt_v = 4'b1000;
    for (int i = 0; i < NREQ; i++) rearm_left[i] = 0;

    // Reset with every request pending and the unit ready: nothing may be issued.
    #1;
    req = 4'b1111;
    tick();
    chk("rst_gnt", 64'(obs_gnt), 64'(0));
    chk("rst_du_en", 64'(obs_du_en), 64'(0));
    chk("rst_busy", 64'(obs_busy), 64'(0));
    chk("rst_resp", 64'(obs_resp), 64'(0));
    req = '0;
    rst_n = 1'b1;
    tick();

    // Single divide from requester 2: same-cycle grant, 5-cycle unit, result 2.0 with tag 2.
    bbase = busy_cnt;
    req[2] = 1'b1;
    push_exp(2);
    tick();
    chk("single_gnt", 64'(obs_gnt), 64'(4'b0100));
    chk("single_du_en", 64'(obs_du_en), 64'(1));
    g0 = cyc;
    wait_idle(40);
    chk("single_latency", 64'(last_resp_cyc - g0), 64'(DU_LAT + RESP_LAT));
    chk("single_busy_cycles", 64'(busy_cnt - bbase), 64'(DU_LAT));
    chk("single_res", 64'(last_res), 64'(32'h4000_0000));
    chk("single_tag", 64'(last_tag), 64'(2));

    // Requester 3 square root moves the pointer back to 0.
    base = gnt_log.size();
    req[3] = 1'b1;
    push_exp(3);
    wait_idle(40);
    chk("sqrt_gnt_count", 64'(gnt_log.size() - base), 64'(1));
    chk("sqrt_gnt_who", 64'(gnt_log[base]), 64'(3));
    chk("sqrt_res", 64'(last_res), 64'(32'h4080_0000));

    // All four pending, requester 0 re-requests once: order 0,1,2,3,0, one grant every 6 cycles.
    base = gnt_log.size();
    rearm_left[0] = 1;
    for (int i = 0; i < NREQ; i++) push_exp(i);
    req = 4'b1111;
    wait_idle(120);
    chk("rr_gnt_count", 64'(gnt_log.size() - base), 64'(5));
    if (gnt_log.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), 64'(gnt_log[base+k]), 64'(rr_exp[k]));
      for (int k = 1; k < 5; k++)
        chk($sformatf("rr_spacing_%0d", k), 64'(gnt_cyc[base+k] - gnt_cyc[base+k-1]), 64'(DU_LAT + 1));
    end

    // Unit not ready: the request waits, then is granted in the cycle ready rises.
    du_ready = 1'b0;
    base = gnt_log.size();
    req = 4'b0001;
    push_exp(0);
    repeat (3) tick();
    chk("noready_no_gnt", 64'(gnt_log.size() - base), 64'(0));
    du_ready = 1'b1;
    tick();
    chk("ready_gnt", 64'(obs_gnt), 64'(4'b0001));
    wait_idle(40);

    // Spurious unit valid while idle.
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    chk("spur_resp", 64'(obs_resp), 64'(0));
    chk("spur_busy", 64'(obs_busy), 64'(0));
    tick();
    chk("spur_state", 64'(obs_busy), 64'(0));
    chk("spur_resp_late", 64'(obs_resp), 64'(0));

    // Reset two cycles into an operation; its late result must be dropped, pointer back to 0.
    req = 4'b0100;
    push_exp(2);
    tick();
    chk("midrst_pre_gnt", 64'(obs_gnt), 64'(4'b0100));
    tick();
    tick();
    chk("midrst_pre_busy", 64'(obs_busy), 64'(1));
    rst_n = 1'b0;
    sb.delete();
    req = 4'b1100;
    repeat (2) begin
      tick();
      chk("midrst_gnt", 64'(obs_gnt), 64'(0));
      chk("midrst_du_en", 64'(obs_du_en), 64'(0));
      chk("midrst_busy", 64'(obs_busy), 64'(0));
      chk("midrst_resp", 64'(obs_resp), 64'(0));
    end
    req = '0;
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("late_valid_resp", 64'(obs_resp), 64'(0));
      chk("late_valid_busy", 64'(obs_busy), 64'(0));
    end
    base = gnt_log.size();
    push_exp(2);
    push_exp(3);
    req = 4'b1100;
    wait_idle(60);
    chk("postrst_gnt_count", 64'(gnt_log.size() - base), 64'(2));
    if (gnt_log.size() >= base + 2) begin
      chk("postrst_first", 64'(gnt_log[base]), 64'(2));
      chk("postrst_second", 64'(gnt_log[base+1]), 64'(3));
    end

    // Three requesters: grant 1 leaves the pointer at 2, then 3'b101 grants 2 before 0.
    req3 = 3'b010;
    repeat (10) tick();
    req3 = 3'b101;
    repeat (16) tick();
    chk("n3_gnt_count", 64'(gnt3_log.size()), 64'(3));
    if (gnt3_log.size() >= 3) begin
      for (int k = 0; k < 3; k++) chk($sformatf("n3_order_%0d", k), 64'(gnt3_log[k]), 64'(n3_exp[k]));
    end
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
